// File: rtl/dll_delay_ctrl.sv
// Delay-line code controller for the FMDLL loop: filters phase-detector votes into a
// saturating delay code, declares lock, and restarts the loop on harmonic-lock events.
module dll_delay_ctrl #(
  parameter int CODE_W    = 6,
  parameter int INIT_CODE = 0,
  parameter int HOLD_CYC  = 4,
  parameter int AVG_N     = 4,
  parameter int LOCK_CNT  = 8
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic              Reset_PD,
  input  logic              en,
  input  logic              up,
  input  logic              dn,
  output logic [CODE_W-1:0] code,
  output logic              lock,
  output logic              hld_event,
  output logic              sat
);

  // state  | meaning
  // IDLE   | loop disabled, code held, filter and reversal count cleared
  // HOLD   | frozen after a harmonic-lock event, votes ignored for HOLD_CYC cycles
  // TRACK  | votes filtered into code steps, counting direction reversals
  // LOCKED | lock declared, steps continue until two same-direction steps in a row
  typedef enum logic [1:0] {IDLE, HOLD, TRACK, LOCKED} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int FILT_W = $clog2(AVG_N + 1) + 1;
  localparam int REV_W  = $clog2(LOCK_CNT + 1);

  localparam logic [CODE_W-1:0]        CODE_INIT = CODE_W'(INIT_CODE);
  localparam logic [CODE_W-1:0]        CODE_MAX  = {CODE_W{1'b1}};
  localparam logic [HOLD_W-1:0]        HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  localparam logic signed [FILT_W-1:0] FILT_POS  = FILT_W'(AVG_N);
  localparam logic signed [FILT_W-1:0] FILT_NEG  = FILT_W'(-AVG_N);
  localparam logic [REV_W-1:0]         REV_LOCK  = REV_W'(LOCK_CNT);

  logic sync1, sync2, sync3, hld_req;

  state_t                    state_q, state_d;
  dir_t                      dir_q, dir_d, step_dir;
  logic [CODE_W-1:0]         code_q, code_d;
  logic signed [FILT_W-1:0]  filt_q, filt_d, filt_sum, vote;
  logic [REV_W-1:0]          rev_q, rev_d, rev_inc;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic                      sat_q, sat_d, hld_event_q, hld_event_d;
  logic                      req_up, req_dn, at_limit;

  always_ff @(posedge clk_ext) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      hld_req     <= 1'b0;
      state_q     <= IDLE;
      dir_q       <= DIR_NONE;
      code_q      <= CODE_INIT;
      filt_q      <= '0;
      rev_q       <= '0;
      hold_q      <= '0;
      sat_q       <= 1'b0;
      hld_event_q <= 1'b0;
    end else begin
      sync1       <= Reset_PD;
      sync2       <= sync1;
      sync3       <= sync2;
      hld_req     <= sync2 & ~sync3;
      state_q     <= state_d;
      dir_q       <= dir_d;
      code_q      <= code_d;
      filt_q      <= filt_d;
      rev_q       <= rev_d;
      hold_q      <= hold_d;
      sat_q       <= sat_d;
      hld_event_q <= hld_event_d;
    end
  end

  always_comb begin
    if (up && !dn)      vote = FILT_W'(1);
    else if (dn && !up) vote = FILT_W'(-1);
    else                vote = '0;
    filt_sum = filt_q + vote;
    req_up   = (filt_sum == FILT_POS);
    req_dn   = (filt_sum == FILT_NEG);
    step_dir = req_up ? DIR_UP : DIR_DN;
    at_limit = req_up ? (code_q == CODE_MAX) : (code_q == '0);
    rev_inc  = rev_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    code_d      = code_q;
    filt_d      = filt_q;
    rev_d       = rev_q;
    hold_d      = hold_q;
    sat_d       = sat_q;
    hld_event_d = 1'b0;

    if (hld_req) begin
      // Harmonic-lock escape wins over any step request on the same edge.
      code_d      = CODE_INIT;
      filt_d      = '0;
      rev_d       = '0;
      dir_d       = DIR_NONE;
      sat_d       = 1'b0;
      hld_event_d = 1'b1;
      hold_d      = HOLD_LOAD;
      state_d     = en ? HOLD : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          filt_d = '0;
          rev_d  = '0;
          dir_d  = DIR_NONE;
          if (en) state_d = TRACK;
        end
        HOLD: begin
          filt_d = '0;
          if (hold_q == '0) state_d = en ? TRACK : IDLE;
          else              hold_d  = hold_q - 1'b1;
        end
        TRACK, LOCKED: begin
          if (!en) begin
            state_d = IDLE;
            filt_d  = '0;
            rev_d   = '0;
            dir_d   = DIR_NONE;
          end else if (req_up || req_dn) begin
            filt_d = '0;
            if (at_limit) begin
              sat_d = 1'b1;
            end else begin
              sat_d  = 1'b0;
              code_d = req_up ? code_q + 1'b1 : code_q - 1'b1;
              dir_d  = step_dir;
              if (state_q == TRACK) begin
                if (dir_q == DIR_NONE || dir_q == step_dir) begin
                  rev_d = REV_W'(1);
                end else begin
                  rev_d = rev_inc;
                  if (rev_inc == REV_LOCK) state_d = LOCKED;
                end
              end else if (dir_q == step_dir) begin
                state_d = TRACK;
                rev_d   = REV_W'(1);
              end
            end
          end else begin
            filt_d = filt_sum;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign code      = code_q;
  assign lock      = (state_q == LOCKED);
  assign hld_event = hld_event_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_dll_delay_ctrl.sv
// Directed bench for dll_delay_ctrl: reset, tracking, saturation (3-bit instance),
// lock/unlock, harmonic-lock restart and the hold-extension corner.
module tb_dll_delay_ctrl;

  logic       clk_ext = 1'b0;
  logic       rst_n, Reset_PD, en, up, dn;
  logic [5:0] code;
  logic       lock, hld_event, sat;
  logic [2:0] code3;
  logic       lock3, hld_event3, sat3;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk_ext = ~clk_ext;

  dll_delay_ctrl dut (
    .clk_ext(clk_ext), .rst_n(rst_n), .Reset_PD(Reset_PD), .en(en), .up(up), .dn(dn),
    .code(code), .lock(lock), .hld_event(hld_event), .sat(sat)
  );

  dll_delay_ctrl #(.CODE_W(3)) dut3 (
    .clk_ext(clk_ext), .rst_n(rst_n), .Reset_PD(Reset_PD), .en(en), .up(up), .dn(dn),
    .code(code3), .lock(lock3), .hld_event(hld_event3), .sat(sat3)
  );

  task automatic do_reset();
    @(negedge clk_ext);
    rst_n = 1'b0; en = 1'b0; up = 1'b0; dn = 1'b0; Reset_PD = 1'b0;
    repeat (2) @(negedge clk_ext);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; up = 1'b1; dn = 1'b0; Reset_PD = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_ext);
      n_cmp++; if (code !== 6'd0) begin n_bad++; $display("FAIL reset_code cyc%0d: got %0d want 0", c, code); end
      n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL reset_lock cyc%0d: got %0b want 0", c, lock); end
      n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat cyc%0d: got %0b want 0", c, sat); end
      n_cmp++; if (hld_event !== 1'b0) begin n_bad++; $display("FAIL reset_hld cyc%0d: got %0b want 0", c, hld_event); end
    end
    en = 1'b0; up = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_tracking();
    do_reset();
    en = 1'b1;
    @(negedge clk_ext);
    up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_ext);
      if (i % 4 == 0) begin
        n_cmp++; if (code !== 6'(i / 4)) begin n_bad++; $display("FAIL track_up vote%0d: got %0d want %0d", i, code, i / 4); end
      end
    end
    up = 1'b0; dn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_ext);
      if (i % 4 == 0) begin
        n_cmp++; if (code !== 6'(5 - i / 4)) begin n_bad++; $display("FAIL track_dn vote%0d: got %0d want %0d", i, code, 5 - i / 4); end
      end
    end
    n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL track_lock: got %0b want 0", lock); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL track_sat: got %0b want 0", sat); end
    dn = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1;
    @(negedge clk_ext);
    up = 1'b1;
    repeat (40) @(negedge clk_ext);
    n_cmp++; if (code3 !== 3'd7) begin n_bad++; $display("FAIL sat_code3: got %0d want 7", code3); end
    n_cmp++; if (sat3 !== 1'b1) begin n_bad++; $display("FAIL sat_flag3: got %0b want 1", sat3); end
    n_cmp++; if (code !== 6'd10) begin n_bad++; $display("FAIL sat_code6: got %0d want 10", code); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL sat_flag6: got %0b want 0", sat); end
    up = 1'b0; dn = 1'b1;
    repeat (3) @(negedge clk_ext);
    n_cmp++; if (code3 !== 3'd7) begin n_bad++; $display("FAIL sat_pre_dn: got %0d want 7", code3); end
    n_cmp++; if (sat3 !== 1'b1) begin n_bad++; $display("FAIL sat_pre_dn_flag: got %0b want 1", sat3); end
    @(negedge clk_ext);
    n_cmp++; if (code3 !== 3'd6) begin n_bad++; $display("FAIL sat_dn_code: got %0d want 6", code3); end
    n_cmp++; if (sat3 !== 1'b0) begin n_bad++; $display("FAIL sat_dn_clear: got %0b want 0", sat3); end
    n_cmp++; if (code !== 6'd9) begin n_bad++; $display("FAIL sat_dn_code6: got %0d want 9", code); end
    dn = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    en = 1'b1;
    @(negedge clk_ext);
    for (int s = 1; s <= 8; s++) begin
      up = (s % 2 == 1); dn = (s % 2 == 0);
      repeat (4) @(negedge clk_ext);
      n_cmp++; if (lock !== (s == 8)) begin n_bad++; $display("FAIL lock_step%0d: got %0b want %0b", s, lock, s == 8); end
      n_cmp++; if (code !== 6'(s % 2)) begin n_bad++; $display("FAIL lock_code%0d: got %0d want %0d", s, code, s % 2); end
    end
    up = 1'b1; dn = 1'b0;
    repeat (4) @(negedge clk_ext);
    n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL unlock_first: got %0b want 1", lock); end
    repeat (4) @(negedge clk_ext);
    n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL unlock_second: got %0b want 0", lock); end
    n_cmp++; if (code !== 6'd2) begin n_bad++; $display("FAIL unlock_code: got %0d want 2", code); end
    up = 1'b0;
  endtask

  task automatic test_harmonic();
    int events;
    do_reset();
    en = 1'b1;
    @(negedge clk_ext);
    up = 1'b1;
    repeat (84) @(negedge clk_ext);
    for (int s = 1; s <= 7; s++) begin
      up = (s % 2 == 0); dn = (s % 2 == 1);
      repeat (4) @(negedge clk_ext);
    end
    n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL hlr_prelock: got %0b want 1", lock); end
    n_cmp++; if (code !== 6'd20) begin n_bad++; $display("FAIL hlr_precode: got %0d want 20", code); end
    up = 1'b0; dn = 1'b0; Reset_PD = 1'b1;
    events = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_ext);
      if (hld_event === 1'b1) events++;
      if (c == 2) begin
        Reset_PD = 1'b0;
        n_cmp++; if (code !== 6'd20) begin n_bad++; $display("FAIL hlr_code_early: got %0d want 20", code); end
      end
    end
    n_cmp++; if (hld_event !== 1'b1) begin n_bad++; $display("FAIL hlr_event: got %0b want 1", hld_event); end
    n_cmp++; if (code !== 6'd0) begin n_bad++; $display("FAIL hlr_code: got %0d want 0", code); end
    n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL hlr_lock: got %0b want 0", lock); end
    up = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk_ext);
      if (hld_event === 1'b1) events++;
      if (j == 7) begin
        n_cmp++; if (code !== 6'd0) begin n_bad++; $display("FAIL hlr_hold_ignore: got %0d want 0", code); end
      end
    end
    n_cmp++; if (code !== 6'd1) begin n_bad++; $display("FAIL hlr_resume: got %0d want 1", code); end
    n_cmp++; if (events != 1) begin n_bad++; $display("FAIL hlr_event_count: got %0d want 1", events); end
    up = 1'b0;
  endtask

  task automatic test_corner();
    do_reset();
    en = 1'b1;
    @(negedge clk_ext);
    up = 1'b1; Reset_PD = 1'b1;
    for (int n = 0; n <= 15; n++) begin
      @(negedge clk_ext);
      if (n == 1) Reset_PD = 1'b0;
      if (n == 3) Reset_PD = 1'b1;
      if (n == 5) Reset_PD = 1'b0;
      if (n == 3) begin
        n_cmp++; if (code !== 6'd0) begin n_bad++; $display("FAIL corner_no_step: got %0d want 0", code); end
        n_cmp++; if (hld_event !== 1'b1) begin n_bad++; $display("FAIL corner_event1: got %0b want 1", hld_event); end
      end
      if (n == 4) begin
        n_cmp++; if (hld_event !== 1'b0) begin n_bad++; $display("FAIL corner_pulse_len: got %0b want 0", hld_event); end
      end
      if (n == 7) begin
        n_cmp++; if (hld_event !== 1'b1) begin n_bad++; $display("FAIL corner_event2: got %0b want 1", hld_event); end
      end
      if (n == 14) begin
        n_cmp++; if (code !== 6'd0) begin n_bad++; $display("FAIL corner_hold_ext: got %0d want 0", code); end
      end
    end
    n_cmp++; if (code !== 6'd1) begin n_bad++; $display("FAIL corner_resume: got %0d want 1", code); end
    up = 1'b0;
  endtask

  task automatic test_en_fall();
    do_reset();
    en = 1'b1;
    @(negedge clk_ext);
    up = 1'b1;
    repeat (3) @(negedge clk_ext);
    en = 1'b0;
    @(negedge clk_ext);
    n_cmp++; if (code !== 6'd0) begin n_bad++; $display("FAIL en_fall_step: got %0d want 0", code); end
    en = 1'b1;
    repeat (4) @(negedge clk_ext);
    n_cmp++; if (code !== 6'd0) begin n_bad++; $display("FAIL en_filter_clear: got %0d want 0", code); end
    @(negedge clk_ext);
    n_cmp++; if (code !== 6'd1) begin n_bad++; $display("FAIL en_resume: got %0d want 1", code); end
    up = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tracking();
    test_saturation();
    test_lock();
    test_harmonic();
    test_corner();
    test_en_fall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
